bnn_host_sequencer: RTL and testbench
=====================================

// Module: bnn_host_sequencer
// PURPOSE
//  Host-side driver for the 9-pin BNN column chip. Buffers one set of O_CH weights, then bursts them in on
//  load_weight. Clears the chip's psums and streams activations with in_valid. Waits for the column pipeline
//  to drain, pops O_CH sign-bit rows, and returns them as a valid/ready result stream.
//  It generates every pin the chip consumes and captures sum_out.
// PARAMETERS
//  O_CH          64   output channels (chip rows); weight and result buffer depth
//  OUT_ROW_LEN   4    sign bits per popped row (chip sum_out width)
//  DRAIN_CYCLES  67   idle cycles between last in_valid and first pop (O_CH-1 skew + PE pipeline)
//  NACT_W        16   width of activation count
// PORTS
//  clk_in        in   1            clock
//  rst_in        in   1            synchronous, active-high reset
//  start_in      in   1            pulse: begin pass (sampled only in IDLE)
//  cmd_load_w_in in   1            with start: 1 = fetch+burst new weights, 0 = reuse chip weights
//  cmd_nact_in   in   NACT_W       with start: activations to stream this pass
//  w_valid_in    in   1            weight stream valid
//  w_data_in     in   9            weight word (channel order 0..O_CH-1)
//  w_ready_out   out  1            weight stream ready
//  a_valid_in    in   1            activation stream valid
//  a_data_in     in   9            activation word
//  a_ready_out   out  1            activation stream ready
//  res_valid_out out  1            result valid
//  res_data_out  out  OUT_ROW_LEN  popped sign bits, MSB = first shifter slot
//  res_ch_out    out  6            channel index of res_data_out
//  res_ready_in  in   1            result ready
//  busy_out      out  1            high whenever state != IDLE
//  chip_data_out out  9            to chip data_in
//  chip_load_out out  1            to chip load_weight_in
//  chip_valid_out out 1            to chip in_valid_in
//  chip_pop_out  out  1            to chip pop_in
//  chip_rst_n_out out 1            to chip rst_in (active low, clears psums)
//  chip_sum_in   in   OUT_ROW_LEN  from chip sum_out
// BEHAVIOUR
//  - All chip_* outputs registered. During rst_in: state IDLE, counters 0, chip_data/load/valid/pop = 0,
//    chip_rst_n = 0, w_ready/a_ready/res_valid/busy = 0. Reset mid-pass aborts; buffers are not cleared.
//  - FSM: IDLE -> (start & load_w) WFILL | (start & !load_w) CLEAR.
//    WFILL: w_ready=1; store accepted words at idx 0..O_CH-1; after O_CH accepts go to WBURST.
//    WBURST: exactly O_CH consecutive cycles with chip_load=1, chip_data=wbuf[k], k=0..O_CH-1; no gaps,
//      since the chip counter restarts when load drops. Then CLEAR.
//    CLEAR: one cycle chip_rst_n=0, then STREAM.
//    STREAM: a_ready=1 until cmd_nact accepted. An accept cycle gives chip_valid=1 and chip_data=a_data next
//      cycle. A bubble gives chip_valid=0 and chip_data=0. nact==0 skips straight to DRAIN.
//    DRAIN: DRAIN_CYCLES cycles with chip_valid=0, then POP.
//    POP: exactly O_CH consecutive chip_pop=1 cycles. On the k-th cycle chip_pop is high at the chip pin
//      (k=0..O_CH-1), capture chip_sum_in into rbuf[k]; this is valid in the same cycle (chip output is
//      combinational). Then OUT.
//    OUT: present rbuf[0..O_CH-1] in order with res_ch = index; advance on res_valid & res_ready. After the
//      last handshake go to IDLE.
//  - start_in outside IDLE is ignored; cmd inputs are latched only on the accepted start.
//  - chip_rst_n=1 in every state except CLEAR and reset. chip_data=0 whenever neither load nor valid is high.
//  - Latency, load_w=0, n activations, no stalls: 1 (CLEAR) + n + DRAIN_CYCLES + O_CH cycles to first res_valid.
// TESTING
//  1 start,load_w=1,nact=0; weights 0x000..0x03F back-to-back -> chip_load high 64 consecutive cycles,
//    chip_data 0x000..0x03F in order; one chip_rst_n low pulse.
//  2 weight stream with valid toggling 1/0 -> WFILL stretches; WBURST still 64 contiguous cycles, same data.
//  3 load_w=0,nact=8, a_valid low every 3rd cycle -> 8 chip_valid pulses with matching data, 0 on bubbles,
//    first pop exactly 67 cycles after last valid.
//  4 chip model drives sum_in = k[3:0] on pop cycle k -> results ch 0..63 with data k[3:0]; hold
//    res_ready=0 10 cycles mid-stream -> no loss, no reorder.
//  5 start asserted during STREAM -> ignored; busy stays 1; pass completes unchanged.
//  6 rst_in high mid-WBURST for 1 cycle -> next cycle all chip_* = 0 except chip_rst_n=0, then 1; IDLE;
//    a new start runs a full pass.

Source files
------------

// File: rtl/bnn_host_sequencer.sv
// bnn_host_sequencer
// Host-side driver for the 9-pin BNN column chip. A pass optionally fetches
// and bursts O_CH weights into the chip. It then clears the chip psums,
// streams activations and waits for the column pipeline to drain. Finally it
// pops O_CH sign-bit rows and returns them on a valid/ready result stream.
// Every chip pin is driven from a flop. The chip pins therefore trail the
// state that requested them by one cycle, and the pop capture follows the
// registered pop pin.

module bnn_host_sequencer #(
  parameter int O_CH         = 64,
  parameter int OUT_ROW_LEN  = 4,
  parameter int DRAIN_CYCLES = 67,
  parameter int NACT_W       = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic                     cmd_load_w_in,
  input  logic [NACT_W-1:0]        cmd_nact_in,
  input  logic                     w_valid_in,
  input  logic [8:0]               w_data_in,
  output logic                     w_ready_out,
  input  logic                     a_valid_in,
  input  logic [8:0]               a_data_in,
  output logic                     a_ready_out,
  output logic                     res_valid_out,
  output logic [OUT_ROW_LEN-1:0]   res_data_out,
  output logic [$clog2(O_CH)-1:0]  res_ch_out,
  input  logic                     res_ready_in,
  output logic                     busy_out,
  output logic [8:0]               chip_data_out,
  output logic                     chip_load_out,
  output logic                     chip_valid_out,
  output logic                     chip_pop_out,
  output logic                     chip_rst_n_out,
  input  logic [OUT_ROW_LEN-1:0]   chip_sum_in
);

  localparam int CW = $clog2(O_CH);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(O_CH - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WFILL, WBURST, CLEAR, STREAM, DRAIN, POP, OUT
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;        // fill / burst / pop-issue / output index
  logic [CW-1:0]       cap_q, cap_d;        // result capture index, follows the pop pin
  logic [NACT_W-1:0]   act_cnt_q, act_cnt_d;
  logic [NACT_W-1:0]   nact_q, nact_d;
  logic [DW-1:0]       drain_q, drain_d;

  logic                w_ready_q, w_ready_d;
  logic                a_ready_q, a_ready_d;
  logic                res_valid_q, res_valid_d;
  logic                busy_q, busy_d;
  logic [8:0]          chip_data_q, chip_data_d;
  logic                chip_load_q, chip_load_d;
  logic                chip_valid_q, chip_valid_d;
  logic                chip_pop_q, chip_pop_d;
  logic                chip_rst_n_q, chip_rst_n_d;

  logic [8:0]             wbuf [O_CH];
  logic [OUT_ROW_LEN-1:0] rbuf [O_CH];

  logic w_acc, a_acc, r_acc;
  assign w_acc = w_ready_q & w_valid_in;
  assign a_acc = a_ready_q & a_valid_in;
  assign r_acc = res_valid_q & res_ready_in;

  // Next-state and next-pin computation for the whole pass sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    cap_d        = cap_q;
    act_cnt_d    = act_cnt_q;
    nact_d       = nact_q;
    drain_d      = drain_q;
    chip_data_d  = '0;
    chip_load_d  = 1'b0;
    chip_valid_d = 1'b0;
    chip_pop_d   = 1'b0;
    chip_rst_n_d = 1'b1;

    if (chip_pop_q) cap_d = cap_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          nact_d    = cmd_nact_in;
          idx_d     = '0;
          act_cnt_d = '0;
          state_d   = cmd_load_w_in ? WFILL : CLEAR;
        end
      end
      WFILL: begin
        if (w_acc) begin
          if (idx_q == LAST_CH) begin
            idx_d   = '0;
            state_d = WBURST;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WBURST: begin
        // The chip weight counter restarts whenever load drops, so the burst never pauses.
        chip_load_d = 1'b1;
        chip_data_d = wbuf[idx_q];
        if (idx_q == LAST_CH) begin
          idx_d   = '0;
          state_d = CLEAR;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CLEAR: begin
        chip_rst_n_d = 1'b0;
        cap_d        = '0;
        act_cnt_d    = '0;
        drain_d      = '0;
        state_d      = (nact_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        if (a_acc) begin
          chip_valid_d = 1'b1;
          chip_data_d  = a_data_in;
          act_cnt_d    = act_cnt_q + 1'b1;
          if (act_cnt_q == nact_q - 1'b1) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          idx_d   = '0;
          state_d = POP;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      POP: begin
        chip_pop_d = 1'b1;
        if (idx_q == LAST_CH) begin
          idx_d   = '0;
          state_d = OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        if (r_acc) begin
          if (idx_q == LAST_CH) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    w_ready_d   = (state_d == WFILL);
    a_ready_d   = (state_d == STREAM);
    res_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  // State, counters and every registered output; synchronous reset aborts a pass.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst_in) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cap_q        <= '0;
      act_cnt_q    <= '0;
      nact_q       <= '0;
      drain_q      <= '0;
      w_ready_q    <= 1'b0;
      a_ready_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      chip_data_q  <= '0;
      chip_load_q  <= 1'b0;
      chip_valid_q <= 1'b0;
      chip_pop_q   <= 1'b0;
      chip_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      act_cnt_q    <= act_cnt_d;
      nact_q       <= nact_d;
      drain_q      <= drain_d;
      w_ready_q    <= w_ready_d;
      a_ready_q    <= a_ready_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      chip_data_q  <= chip_data_d;
      chip_load_q  <= chip_load_d;
      chip_valid_q <= chip_valid_d;
      chip_pop_q   <= chip_pop_d;
      chip_rst_n_q <= chip_rst_n_d;
    end
  end

  // Weight and result buffers: written on accepted words and on registered pop cycles.
  always_ff @(posedge clk_in) begin
    // NOTE: the buffers are deliberately not reset; a reset mid-pass keeps their contents and every pass rewrites them before use.
    if (w_acc) wbuf[idx_q] <= w_data_in;
    if (chip_pop_q) rbuf[cap_q] <= chip_sum_in;
  end

  assign w_ready_out    = w_ready_q;
  assign a_ready_out    = a_ready_q;
  assign res_valid_out  = res_valid_q;
  assign res_data_out   = rbuf[idx_q];
  assign res_ch_out     = idx_q;
  assign busy_out       = busy_q;
  assign chip_data_out  = chip_data_q;
  assign chip_load_out  = chip_load_q;
  assign chip_valid_out = chip_valid_q;
  assign chip_pop_out   = chip_pop_q;
  assign chip_rst_n_out = chip_rst_n_q;

endmodule

// File: tb/tb_bnn_host_sequencer.sv
// tb_bnn_host_sequencer
// Directed bench for bnn_host_sequencer. It includes a tiny chip model that
// returns k[3:0] on the k-th pop after a psum clear. Inputs change just after
// the falling edge. Outputs are sampled at the falling edge.

module tb_bnn_host_sequencer;

  localparam int O_CH  = 64;
  localparam int DRAIN = 67;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        cmd_load_w_in;
  logic [15:0] cmd_nact_in;
  logic        w_valid_in;
  logic [8:0]  w_data_in;
  logic        w_ready_out;
  logic        a_valid_in;
  logic [8:0]  a_data_in;
  logic        a_ready_out;
  logic        res_valid_out;
  logic [3:0]  res_data_out;
  logic [5:0]  res_ch_out;
  logic        res_ready_in;
  logic        busy_out;
  logic [8:0]  chip_data_out;
  logic        chip_load_out;
  logic        chip_valid_out;
  logic        chip_pop_out;
  logic        chip_rst_n_out;
  logic [3:0]  chip_sum_in;

  always #5 clk_in = ~clk_in;

  bnn_host_sequencer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .cmd_load_w_in (cmd_load_w_in),
    .cmd_nact_in   (cmd_nact_in),
    .w_valid_in    (w_valid_in),
    .w_data_in     (w_data_in),
    .w_ready_out   (w_ready_out),
    .a_valid_in    (a_valid_in),
    .a_data_in     (a_data_in),
    .a_ready_out   (a_ready_out),
    .res_valid_out (res_valid_out),
    .res_data_out  (res_data_out),
    .res_ch_out    (res_ch_out),
    .res_ready_in  (res_ready_in),
    .busy_out      (busy_out),
    .chip_data_out (chip_data_out),
    .chip_load_out (chip_load_out),
    .chip_valid_out(chip_valid_out),
    .chip_pop_out  (chip_pop_out),
    .chip_rst_n_out(chip_rst_n_out),
    .chip_sum_in   (chip_sum_in)
  );

  // Chip model: the pop counter clears with psums; sum_out is combinational.
  int pop_k = 0;
  always @(posedge clk_in) begin
    if (!chip_rst_n_out) pop_k <= 0;
    else if (chip_pop_out) pop_k <= pop_k + 1;
  end
  assign chip_sum_in = chip_pop_out ? 4'(pop_k) : 4'h0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pin monitor state, updated once per falling edge by tick().
  int         cyc;
  logic [8:0] load_log[$];
  logic [8:0] valid_log[$];
  int         res_ch_log[$];
  int         res_dat_log[$];
  int         load_runs, pop_cnt, pop_runs, rstn_pulses, rstn_low, data_bad;
  int         last_valid_cyc, first_pop_cyc, first_res_cyc, rstn_cyc;
  bit         prev_load, prev_pop, prev_rstn;

  task automatic mon_clear();
    load_log.delete(); valid_log.delete(); res_ch_log.delete(); res_dat_log.delete();
    load_runs = 0; pop_cnt = 0; pop_runs = 0; rstn_pulses = 0; rstn_low = 0; data_bad = 0;
    last_valid_cyc = -1; first_pop_cyc = -1; first_res_cyc = -1; rstn_cyc = -1;
    prev_load = chip_load_out; prev_pop = chip_pop_out; prev_rstn = chip_rst_n_out;
  endtask

  task automatic tick();
    @(negedge clk_in);
    cyc++;
    if (chip_load_out) begin
      load_log.push_back(chip_data_out);
      if (!prev_load) load_runs++;
    end
    if (chip_valid_out) begin
      valid_log.push_back(chip_data_out);
      last_valid_cyc = cyc;
    end
    if (!chip_load_out && !chip_valid_out && chip_data_out != 9'd0) data_bad++;
    if (chip_load_out && chip_valid_out) data_bad++;
    if (!chip_rst_n_out) begin
      rstn_low++;
      if (prev_rstn) begin rstn_pulses++; rstn_cyc = cyc; end
    end
    if (chip_pop_out) begin
      pop_cnt++;
      if (!prev_pop) begin
        pop_runs++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    if (res_valid_out && first_res_cyc < 0) first_res_cyc = cyc;
    prev_load = chip_load_out; prev_pop = chip_pop_out; prev_rstn = chip_rst_n_out;
  endtask

  // Runs one full pass and checks every observable property of it.
  task automatic run_pass(input bit load_w, input int nact, input int w_base, input bit w_toggle,
                          input int a_base, input bit a_bubble, input int stall_at,
                          input bit poke, input bit check_lat);
    int  wi = 0, ai = 0, lc = 0, start_cyc = 0, stall_n = 0, stall_bad = 0, bad = 0;
    bit  poked = 0, w_acc, a_acc, done;
    mon_clear();
    while (!(res_ch_log.size() == O_CH && !busy_out) && lc < 3000) begin
      start_in      = (lc == 0);
      cmd_load_w_in = (lc == 0) ? load_w : ~load_w;
      cmd_nact_in   = (lc == 0) ? 16'(nact) : 16'hABCD;
      if (poke && a_ready_out && ai == 2 && !poked) begin
        start_in = 1'b1; cmd_load_w_in = 1'b1; cmd_nact_in = 16'd3; poked = 1;
      end
      w_valid_in = (wi < O_CH) && (!w_toggle || lc[0]);
      w_data_in  = 9'(w_base + wi);
      a_valid_in = (ai < nact) && !(a_bubble && (lc % 3 == 2));
      a_data_in  = 9'(a_base + ai);
      res_ready_in = 1'b1;
      if (stall_at >= 0 && res_ch_log.size() == stall_at && stall_n < 10) begin
        res_ready_in = 1'b0;
        stall_n++;
        if (!res_valid_out) stall_bad++;
      end
      w_acc = w_valid_in && w_ready_out;
      a_acc = a_valid_in && a_ready_out;
      if (res_valid_out && res_ready_in) begin
        res_ch_log.push_back(int'(res_ch_out));
        res_dat_log.push_back(int'(res_data_out));
      end
      tick();
      if (lc == 0) start_cyc = cyc;
      if (w_acc) wi++;
      if (a_acc) ai++;
      lc++;
    end
    start_in = 1'b0; w_valid_in = 1'b0; a_valid_in = 1'b0; res_ready_in = 1'b0;
    done = (res_ch_log.size() == O_CH) && !busy_out;
    check("pass_done", done, 1);
    check("load_cycles", load_log.size(), load_w ? O_CH : 0);
    if (load_w) begin
      check("load_runs", load_runs, 1);
      bad = 0;
      foreach (load_log[i]) if (load_log[i] != 9'(w_base + i)) bad++;
      check("load_data_errs", bad, 0);
    end
    check("rstn_pulses", rstn_pulses, 1);
    check("rstn_low_cycles", rstn_low, 1);
    check("valid_cycles", valid_log.size(), nact);
    bad = 0;
    foreach (valid_log[i]) if (valid_log[i] != 9'(a_base + i)) bad++;
    check("valid_data_errs", bad, 0);
    check("idle_data_zero", data_bad, 0);
    if (nact > 0) check("drain_gap", first_pop_cyc - last_valid_cyc - 1, DRAIN);
    else          check("drain_gap_clear", first_pop_cyc - rstn_cyc - 1, DRAIN);
    check("pop_cycles", pop_cnt, O_CH);
    check("pop_runs", pop_runs, 1);
    check("res_count", res_ch_log.size(), O_CH);
    bad = 0;
    foreach (res_ch_log[i]) if (res_ch_log[i] != i || res_dat_log[i] != (i % 16)) bad++;
    check("res_order_errs", bad, 0);
    if (stall_at >= 0) begin
      check("stall_cycles", stall_n, 10);
      check("stall_valid_held", stall_bad, 0);
    end
    if (check_lat) check("latency", first_res_cyc - start_cyc, 1 + nact + DRAIN + O_CH);
  endtask

  initial begin
    int lc, cnt, wi;
    bit acc;
    rst_in = 1'b1; start_in = 1'b0; cmd_load_w_in = 1'b0; cmd_nact_in = '0;
    w_valid_in = 1'b0; w_data_in = '0; a_valid_in = 1'b0; a_data_in = '0; res_ready_in = 1'b0;
    cyc = 0;
    repeat (3) tick();
    check("rst_chip_pins", {chip_load_out, chip_valid_out, chip_pop_out, chip_rst_n_out}, 0);
    check("rst_chip_data", chip_data_out, 0);
    check("rst_handshake", {w_ready_out, a_ready_out, res_valid_out, busy_out}, 0);
    rst_in = 1'b0;
    tick();
    check("post_rst_rstn", chip_rst_n_out, 1);

    // 1: fresh weights 0x000..0x03F back to back, no activations.
    run_pass(1, 0, 0, 0, 0, 0, -1, 0, 0);
    // 2: weight valid toggling stretches WFILL only.
    run_pass(1, 4, 9'h1C0, 1, 9'h055, 0, -1, 0, 0);
    // 3+4: reuse weights, 8 activations with bubbles, result stall mid-stream.
    run_pass(0, 8, 0, 0, 9'h120, 1, 20, 0, 0);
    // Latency with no stalls.
    run_pass(0, 5, 0, 0, 9'h0A0, 0, -1, 0, 1);
    // 5: start poked during STREAM is ignored.
    run_pass(0, 6, 0, 0, 9'h1F0, 0, -1, 1, 0);
    repeat (5) tick();
    check("poke_back_idle", busy_out, 0);

    // 6: reset for one cycle in the middle of the weight burst.
    mon_clear();
    lc = 0; cnt = 0; wi = 0;
    while (cnt < 10 && lc < 500) begin
      start_in = (lc == 0); cmd_load_w_in = 1'b1; cmd_nact_in = 16'd2;
      w_valid_in = (wi < O_CH); w_data_in = 9'(wi);
      acc = w_valid_in && w_ready_out;
      tick();
      if (acc) wi++;
      if (chip_load_out) cnt++;
      lc++;
    end
    check("burst_reached", cnt, 10);
    start_in = 1'b0; w_valid_in = 1'b0; rst_in = 1'b1;
    tick();
    check("abort_chip_pins", {chip_load_out, chip_valid_out, chip_pop_out, chip_rst_n_out}, 0);
    check("abort_chip_data", chip_data_out, 0);
    check("abort_handshake", {w_ready_out, a_ready_out, res_valid_out, busy_out}, 0);
    rst_in = 1'b0;
    tick();
    check("abort_rstn_release", chip_rst_n_out, 1);
    check("abort_idle", busy_out, 0);
    run_pass(1, 3, 9'h0C3, 0, 9'h011, 0, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
